mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS core. Sequences fetch, decode, execute, memory and write-back over several cycles.
- Drives every datapath select and strobe: PC, IR, GRF, ALU, DM, NPC, and the immediate extender's ExtOp.
- Handshakes with a shared instruction/data memory port that may insert wait states.
- Keeps a retired-instruction counter for the bench and debug.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps at 2^CNT_W)
TRAP_ON_ILLEGAL, 1, 1 = unknown opcode/funct enters sticky TRAP; 0 = treated as nop

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
op  in  6  IR[31:26], stable from DECODE until next FETCH completes
funct  in  6  IR[5:0]
zero  in  1  ALU equal flag
mem_ready  in  1  memory port completion, sampled on rising clk
mem_req  out  1  memory request (fetch or data)
mem_we  out  1  data write enable, valid only with mem_req in MEM
mem_sel  out  1  0 = instruction address (PC), 1 = data address (ALU result reg)
pc_wr  out  1  PC load strobe
ir_wr  out  1  IR load strobe
reg_wr  out  1  GRF write strobe
ext_op  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
alu_src  out  1  0 = rt, 1 = ext imm
alu_op  out  2  0 ADD, 1 SUB, 2 OR
reg_dst  out  2  0 rt, 1 rd, 2 $31
mem_to_reg  out  2  0 ALU, 1 mem data, 2 PC (link)
npc_op  out  2  0 PC+4, 1 branch, 2 jump(26-bit), 3 jr(rs)
state  out  3  current state (debug)
trap  out  1  illegal instruction seen, sticky
retired  out  CNT_W  instructions completed since reset

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Registered state; outputs are combinational from state, op, funct and zero.
- Reset (async, reset=0): state=FETCH, trap=0, retired=0. All strobes and mem_req are forced to 0 while reset is low, including when reset hits mid-wait. The selects default to 0.
- FETCH: mem_req=1, mem_sel=0.
  - mem_ready=0: hold.
  - mem_ready=1: same cycle ir_wr=1, pc_wr=1, npc_op=0; go to DECODE.
- DECODE:
  - j: pc_wr, npc_op=2; retire; go to FETCH.
  - jal: as j, plus reg_wr, reg_dst=2, mem_to_reg=2 (link = PC already incremented); retire.
  - jr (op 0, funct 08): pc_wr, npc_op=3; retire.
  - nop (op 0, funct 00): retire; go to FETCH.
  - addu(21)/subu(23)/ori(0D)/lui(0F)/lw(23)/sw(2B)/beq(04): go to EXEC.
  - Anything else: TRAP if TRAP_ON_ILLEGAL, else retire as nop.
- EXEC:
  - addu: alu_op=0, alu_src=0.
  - subu: alu_op=1, alu_src=0.
  - ori: alu_op=2, alu_src=1, ext_op=0.
  - lui: alu_op=0, alu_src=1, ext_op=2.
  - lw/sw: alu_op=0, alu_src=1, ext_op=1; go to MEM.
  - beq: alu_op=1, alu_src=0, ext_op=1. pc_wr=zero with npc_op=1; retire; go to FETCH.
  - All other EXEC ops go to WB.
- MEM: mem_req=1, mem_sel=1, mem_we=(op==sw). Hold until mem_ready.
  - sw: retire; go to FETCH.
  - lw: go to WB.
- WB: reg_wr=1; retire; go to FETCH.
  - R-type: reg_dst=1, mem_to_reg=0.
  - ori/lui: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
- TRAP: all strobes 0, mem_req=0. Stays in TRAP with trap=1 until reset.
- retire: retired increments by 1 on the clock edge ending an instruction's last state; wraps to 0.
- CPI: j/jal/jr/nop 2; beq 3; R/ori/lui 4; sw 4; lw 5. Each mem_ready=0 cycle adds one.
- mem_ready asserted while mem_req=0 is ignored.
- ext_op outside EXEC is 0. Value 3 is never driven.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings;
  - opcode/funct constants;
  - ExtOp, ALUOp, RegDst, MemtoReg and NPCOp encodings. The extender and datapath import the same ExtOp values.
- One natural sub-module, mc_decode: combinational op/funct to instruction-class one-hot plus an illegal flag. mc_ctrl holds the FSM, strobes and counter.

Test Plan:
- ori (op 0D), mem_ready always 1 -> states 0,1,2,4. EXEC: ext_op=0, alu_src=1, alu_op=2. WB: reg_wr=1, reg_dst=0. retired=1 after 4 cycles.
- lw (op 23), mem_ready low 2 cycles in FETCH and 3 in MEM -> 10 cycles total. ext_op=1 in EXEC, mem_we=0, mem_to_reg=1 in WB, single ir_wr pulse.
- beq (op 04) with zero=1, then with zero=0 -> pc_wr=1 with npc_op=1 in EXEC for the first, pc_wr=0 for the second. Both take 3 cycles and retired advances by 2.
- jal (op 03) -> DECODE cycle has pc_wr=1, npc_op=2, reg_wr=1, reg_dst=2, mem_to_reg=2. Back in FETCH at cycle 3.
- Illegal op 3F with TRAP_ON_ILLEGAL=1 -> state=5, trap=1, mem_req=0 forever. Drop reset to 0 -> state=0, trap=0, retired=0.
- Reset asserted mid-MEM wait of sw -> mem_req and mem_we drop asynchronously. After release: FETCH, mem_sel=0, no retire counted.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its datapath.
package mc_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   // Primary opcodes (IR[31:26])
   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [OP_W-1:0] FN_NOP  = 6'h00;
   localparam logic [OP_W-1:0] FN_JR   = 6'h08;
   localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
   localparam logic [OP_W-1:0] FN_SUBU = 6'h23;

   typedef enum logic [SEL_W-1:0] {
      EXT_ZERO = 2'd0,
      EXT_SIGN = 2'd1,
      EXT_LUI  = 2'd2
   } ext_op_e;

   typedef enum logic [SEL_W-1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_OR  = 2'd2
   } alu_op_e;

   typedef enum logic [SEL_W-1:0] {
      DST_RT = 2'd0,
      DST_RD = 2'd1,
      DST_RA = 2'd2
   } reg_dst_e;

   typedef enum logic [SEL_W-1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC  = 2'd2
   } mem_to_reg_e;

   typedef enum logic [SEL_W-1:0] {
      NPC_PC4    = 2'd0,
      NPC_BRANCH = 2'd1,
      NPC_JUMP   = 2'd2,
      NPC_JR     = 2'd3
   } npc_op_e;

   // One-hot instruction class produced by the decoder
   typedef struct packed {
      logic nop;
      logic jr;
      logic addu;
      logic subu;
      logic j;
      logic jal;
      logic beq;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
   } insn_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct to one-hot instruction class, plus an illegal-instruction flag.
module mc_decode
   import mc_pkg::*;
(
   input  logic [OP_W-1:0] op_i,
   input  logic [OP_W-1:0] funct_i,
   output insn_cls_t       cls_o,
   output logic            illegal_o
);

   // Classify the instruction held in IR
   always_comb begin
      cls_o     = '0;
      illegal_o = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_NOP:  cls_o.nop  = 1'b1;
               FN_JR:   cls_o.jr   = 1'b1;
               FN_ADDU: cls_o.addu = 1'b1;
               FN_SUBU: cls_o.subu = 1'b1;
               default: illegal_o  = 1'b1;
            endcase
         end
         OP_J:    cls_o.j   = 1'b1;
         OP_JAL:  cls_o.jal = 1'b1;
         OP_BEQ:  cls_o.beq = 1'b1;
         OP_ORI:  cls_o.ori = 1'b1;
         OP_LUI:  cls_o.lui = 1'b1;
         OP_LW:   cls_o.lw  = 1'b1;
         OP_SW:   cls_o.sw  = 1'b1;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FSM, datapath strobes/selects, retired counter.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned CNT_W           = 32,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic [OP_W-1:0]    funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               mem_sel,
   output logic               pc_wr,
   output logic               ir_wr,
   output logic               reg_wr,
   output logic [SEL_W-1:0]   ext_op,
   output logic               alu_src,
   output logic [SEL_W-1:0]   alu_op,
   output logic [SEL_W-1:0]   reg_dst,
   output logic [SEL_W-1:0]   mem_to_reg,
   output logic [SEL_W-1:0]   npc_op,
   output logic [STATE_W-1:0] state,
   output logic               trap,
   output logic [CNT_W-1:0]   retired
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire_c;
   insn_cls_t        cls;
   logic             illegal;

   mc_decode u_decode (
      .op_i      (op),
      .funct_i   (funct),
      .cls_o     (cls),
      .illegal_o (illegal)
   );

   // Next state and per-state datapath controls; everything is held at zero while in reset
   always_comb begin
      state_d    = state_q;
      retire_c   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_sel    = 1'b0;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      ext_op     = EXT_ZERO;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      reg_dst    = DST_RT;
      mem_to_reg = WB_ALU;
      npc_op     = NPC_PC4;

      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_wr   = 1'b1;
               pc_wr   = 1'b1;
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (cls.j || cls.jal) begin
               pc_wr    = 1'b1;
               npc_op   = NPC_JUMP;
               retire_c = 1'b1;
               state_d  = ST_FETCH;
               if (cls.jal) begin
                  // PC already holds PC+4, which is the link value
                  reg_wr     = 1'b1;
                  reg_dst    = DST_RA;
                  mem_to_reg = WB_PC;
               end
            end else if (cls.jr) begin
               pc_wr    = 1'b1;
               npc_op   = NPC_JR;
               retire_c = 1'b1;
               state_d  = ST_FETCH;
            end else if (cls.nop) begin
               retire_c = 1'b1;
               state_d  = ST_FETCH;
            end else if (illegal) begin
               if (TRAP_ON_ILLEGAL) begin
                  state_d = ST_TRAP;
               end else begin
                  retire_c = 1'b1;
                  state_d  = ST_FETCH;
               end
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_d = ST_WB;
            if (cls.subu) begin
               alu_op = ALU_SUB;
            end else if (cls.ori) begin
               alu_op  = ALU_OR;
               alu_src = 1'b1;
            end else if (cls.lui) begin
               alu_src = 1'b1;
               ext_op  = EXT_LUI;
            end else if (cls.lw || cls.sw) begin
               alu_src = 1'b1;
               ext_op  = EXT_SIGN;
               state_d = ST_MEM;
            end else if (cls.beq) begin
               alu_op   = ALU_SUB;
               ext_op   = EXT_SIGN;
               npc_op   = NPC_BRANCH;
               pc_wr    = zero;
               retire_c = 1'b1;
               state_d  = ST_FETCH;
            end
         end

         ST_MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = cls.sw;
            if (mem_ready) begin
               if (cls.sw) begin
                  retire_c = 1'b1;
                  state_d  = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end

         ST_WB: begin
            reg_wr   = 1'b1;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
            if (cls.lw) begin
               mem_to_reg = WB_MEM;
            end else if (cls.addu || cls.subu) begin
               reg_dst = DST_RD;
            end
         end

         ST_TRAP: state_d = ST_TRAP;

         default: state_d = ST_FETCH;
      endcase

      if (!reset) begin
         retire_c   = 1'b0;
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         mem_sel    = 1'b0;
         pc_wr      = 1'b0;
         ir_wr      = 1'b0;
         reg_wr     = 1'b0;
         ext_op     = EXT_ZERO;
         alu_src    = 1'b0;
         alu_op     = ALU_ADD;
         reg_dst    = DST_RT;
         mem_to_reg = WB_ALU;
         npc_op     = NPC_PC4;
      end
   end

   // Retired count wraps naturally at 2^CNT_W
   assign retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;

   // State register and retired-instruction counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   assign state   = state_q;
   assign trap    = (state_q == ST_TRAP);
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized instruction-level bench for mc_ctrl with a per-instruction reference model.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  op, funct;
   logic        zero, mem_ready;
   logic        mem_req, mem_we, mem_sel, pc_wr, ir_wr, reg_wr, alu_src, trap;
   logic [1:0]  ext_op, alu_op, reg_dst, mem_to_reg, npc_op;
   logic [2:0]  state;
   logic [31:0] retired;

   int n_checks = 0;
   int n_errors = 0;
   int exp_retired = 0;

   always #5 clk = ~clk;

   mc_ctrl #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .ext_op(ext_op),
      .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .npc_op(npc_op), .state(state), .trap(trap), .retired(retired)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Instruction-level expectations: cycle count, strobe pulse counts and select values
   typedef struct {
      int base;      // cycles with no wait states
      bit has_mem;
      bit has_exec;
      int pc_wr_n;
      int npc;       // npc_op on the last PC write
      int reg_wr_n;
      int rd;
      int m2r;
      int alu_op;
      int alu_src;
      int ext_op;
      bit wr_mem;
   } exp_t;

   function automatic exp_t model(input logic [5:0] o, input logic [5:0] f, input logic z);
      exp_t e;
      e.base = 2; e.has_mem = 0; e.has_exec = 0; e.pc_wr_n = 1; e.npc = 0;
      e.reg_wr_n = 0; e.rd = 0; e.m2r = 0; e.alu_op = 0; e.alu_src = 0;
      e.ext_op = 0; e.wr_mem = 0;
      if (o == 6'h02) begin
         e.pc_wr_n = 2; e.npc = 2;
      end else if (o == 6'h03) begin
         e.pc_wr_n = 2; e.npc = 2; e.reg_wr_n = 1; e.rd = 2; e.m2r = 2;
      end else if (o == 6'h00 && f == 6'h08) begin
         e.pc_wr_n = 2; e.npc = 3;
      end else if (o == 6'h00 && f == 6'h00) begin
         e.base = 2;
      end else begin
         e.base = 4; e.has_exec = 1; e.reg_wr_n = 1;
         if (o == 6'h00 && f == 6'h21) begin
            e.rd = 1;
         end else if (o == 6'h00 && f == 6'h23) begin
            e.rd = 1; e.alu_op = 1;
         end else if (o == 6'h0D) begin
            e.alu_op = 2; e.alu_src = 1;
         end else if (o == 6'h0F) begin
            e.alu_src = 1; e.ext_op = 2;
         end else if (o == 6'h23) begin
            e.base = 5; e.has_mem = 1; e.alu_src = 1; e.ext_op = 1; e.m2r = 1;
         end else if (o == 6'h2B) begin
            e.has_mem = 1; e.reg_wr_n = 0; e.alu_src = 1; e.ext_op = 1; e.wr_mem = 1;
         end else if (o == 6'h04) begin
            e.base = 3; e.reg_wr_n = 0; e.alu_op = 1; e.ext_op = 1;
            e.pc_wr_n = z ? 2 : 1; e.npc = z ? 1 : 0;
         end
      end
      return e;
   endfunction

   // Runs one instruction starting in FETCH; called just after a falling edge
   task automatic run_insn(input int id, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fw, input int mw);
      exp_t e;
      int len, fw_left, mw_left;
      int n_ir, n_pc, n_rw, n_req, n_we, last_npc, got_rd, got_m2r;
      int got_alu, got_src, got_ext, bad_ext;
      e = model(o, f, z);
      len = e.base + fw + (e.has_mem ? mw : 0);
      fw_left = fw; mw_left = mw;
      n_ir = 0; n_pc = 0; n_rw = 0; n_req = 0; n_we = 0; last_npc = -1;
      got_rd = -1; got_m2r = -1; got_alu = -1; got_src = -1; got_ext = -1; bad_ext = 0;
      op = o; funct = f; zero = z;
      for (int c = 0; c < len; c++) begin
         #1;
         if (mem_req && !mem_sel) begin
            mem_ready = (fw_left == 0);
            if (fw_left > 0) fw_left--;
         end else if (mem_req) begin
            mem_ready = (mw_left == 0);
            if (mw_left > 0) mw_left--;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         if (ir_wr)   n_ir++;
         if (mem_req) n_req++;
         if (mem_we)  n_we++;
         if (pc_wr) begin n_pc++; last_npc = int'(npc_op); end
         if (reg_wr) begin n_rw++; got_rd = int'(reg_dst); got_m2r = int'(mem_to_reg); end
         if (state == 3'd2) begin
            got_alu = int'(alu_op); got_src = int'(alu_src); got_ext = int'(ext_op);
         end else if (ext_op != 2'd0) begin
            bad_ext++;
         end
         @(negedge clk);
      end
      exp_retired++;
      #1;
      check($sformatf("i%0d end_state", id), 32'(state), 32'd0);
      check($sformatf("i%0d retired", id), retired, 32'(exp_retired));
      check($sformatf("i%0d ir_wr_n", id), 32'(n_ir), 32'd1);
      check($sformatf("i%0d pc_wr_n", id), 32'(n_pc), 32'(e.pc_wr_n));
      check($sformatf("i%0d npc_last", id), 32'(last_npc), 32'(e.npc));
      check($sformatf("i%0d reg_wr_n", id), 32'(n_rw), 32'(e.reg_wr_n));
      check($sformatf("i%0d mem_req_n", id), 32'(n_req),
            32'(fw + 1 + (e.has_mem ? mw + 1 : 0)));
      check($sformatf("i%0d mem_we_n", id), 32'(n_we), 32'(e.wr_mem ? mw + 1 : 0));
      check($sformatf("i%0d ext_outside", id), 32'(bad_ext), 32'd0);
      if (e.reg_wr_n > 0) begin
         check($sformatf("i%0d reg_dst", id), 32'(got_rd), 32'(e.rd));
         check($sformatf("i%0d mem_to_reg", id), 32'(got_m2r), 32'(e.m2r));
      end
      if (e.has_exec) begin
         check($sformatf("i%0d alu_op", id), 32'(got_alu), 32'(e.alu_op));
         check($sformatf("i%0d alu_src", id), 32'(got_src), 32'(e.alu_src));
         check($sformatf("i%0d ext_op", id), 32'(got_ext), 32'(e.ext_op));
      end
   endtask

   function automatic logic [11:0] pick(input int idx);
      case (idx)
         0:  return {6'h00, 6'h00};   // nop
         1:  return {6'h00, 6'h08};   // jr
         2:  return {6'h00, 6'h21};   // addu
         3:  return {6'h00, 6'h23};   // subu
         4:  return {6'h02, 6'h00};   // j
         5:  return {6'h03, 6'h00};   // jal
         6:  return {6'h04, 6'h00};   // beq
         7:  return {6'h0D, 6'h00};   // ori
         8:  return {6'h0F, 6'h00};   // lui
         9:  return {6'h23, 6'h00};   // lw
         default: return {6'h2B, 6'h00};   // sw
      endcase
   endfunction

   initial begin
      logic [11:0] ins;
      reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;

      // Reset state, with mem_ready high to show strobes stay gated
      #12;
      check("rst state", 32'(state), 32'd0);
      check("rst trap", 32'(trap), 32'd0);
      check("rst retired", retired, 32'd0);
      check("rst mem_req", 32'(mem_req), 32'd0);
      check("rst ir_wr", 32'(ir_wr), 32'd0);
      check("rst pc_wr", 32'(pc_wr), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      exp_retired = 0;

      // Directed cases
      run_insn(0, 6'h0D, 6'h00, 1'b0, 0, 0);   // ori
      run_insn(1, 6'h23, 6'h00, 1'b0, 2, 3);   // lw, 10 cycles
      run_insn(2, 6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
      run_insn(3, 6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
      run_insn(4, 6'h03, 6'h00, 1'b0, 0, 0);   // jal

      // Random instruction stream with random wait states
      for (int k = 0; k < 40; k++) begin
         ins = pick(int'($urandom_range(0, 10)));
         run_insn(10 + k, ins[11:6], ins[5:0], 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // sw interrupted by reset while waiting in MEM
      op = 6'h2B; funct = 6'h00; zero = 1'b0;
      #1 mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("sw mem state", 32'(state), 32'd3);
      check("sw mem_req", 32'(mem_req), 32'd1);
      check("sw mem_we", 32'(mem_we), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("sw rst mem_req", 32'(mem_req), 32'd0);
      check("sw rst mem_we", 32'(mem_we), 32'd0);
      check("sw rst state", 32'(state), 32'd0);
      check("sw rst retired", retired, 32'd0);
      exp_retired = 0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("sw rel state", 32'(state), 32'd0);
      check("sw rel mem_sel", 32'(mem_sel), 32'd0);
      check("sw rel mem_req", 32'(mem_req), 32'd1);
      check("sw rel retired", retired, 32'd0);

      // Illegal opcode traps until reset
      op = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
      @(negedge clk);
      #1 check("ill decode", 32'(state), 32'd1);
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         mem_ready = 1'($urandom_range(0, 1));
         #1;
         check($sformatf("trap%0d state", k), 32'(state), 32'd5);
         check($sformatf("trap%0d flag", k), 32'(trap), 32'd1);
         check($sformatf("trap%0d strobes", k),
               32'({mem_req, mem_we, pc_wr, ir_wr, reg_wr}), 32'd0);
         @(negedge clk);
      end
      check("trap retired", retired, 32'(exp_retired));
      reset = 1'b0;
      #1;
      check("trap rst state", 32'(state), 32'd0);
      check("trap rst flag", 32'(trap), 32'd0);
      check("trap rst retired", retired, 32'd0);
      exp_retired = 0;
      @(negedge clk);
      reset = 1'b1;
      run_insn(99, 6'h0D, 6'h00, 1'b0, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
